// File: rtl/transfer_pkg.sv
// Shared types for the two-source transfer pipeline.
// Stage bundle, source tags, stage-pair state codes.
package transfer_pkg;

  localparam int DATA_W = 4;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // {vA, vB}
  localparam logic [1:0] ST_EMPTY  = 2'b00;
  localparam logic [1:0] ST_A_ONLY = 2'b10;
  localparam logic [1:0] ST_B_ONLY = 2'b01;
  localparam logic [1:0] ST_FULL   = 2'b11;

  typedef struct packed {
    logic              valid;
    logic              src;
    logic [DATA_W-1:0] data;
  } stage_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports: en_i, req_i[1:0], last_i (last winner), gnt_o[1:0] one-hot or zero.
module rr_arbiter2
  import transfer_pkg::*;
(
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (1'b1)
        (req_i == 2'b11):
          gnt_o = (last_i == SRC0) ? 2'b10 : 2'b01;
        (req_i == 2'b01): gnt_o = 2'b01;
        (req_i == 2'b10): gnt_o = 2'b10;
        default:          gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/parallel_transfer_arbiter.sv
// Two requesters share a 2-stage (A->B) transfer pipe.
// Ports: req/data/gnt per source, out_* valid/ready side, cnt0/cnt1.
module parallel_transfer_arbiter
  import transfer_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  stage_t           a_q, a_d;
  stage_t           b_q, b_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic       out_fire;
  logic       move_b;
  logic       can_accept;
  logic       arb_en;
  logic [1:0] gnt;

  assign out_fire   = b_q.valid & out_ready;
  assign move_b     = ~b_q.valid | out_fire;
  assign can_accept = ~a_q.valid | move_b;
  assign arb_en     = can_accept & ~flush & ~rst;

  rr_arbiter2 u_arb (
    .en_i   (arb_en),
    .req_i  ({req1, req0}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    last_d = last_q;
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;

    if (move_b) b_d = a_q;

    if (|gnt) begin
      a_d.valid = 1'b1;
      a_d.src   = gnt[1];
      a_d.data  = gnt[1] ? data1 : data0;
      last_d    = gnt[1];
    end else if (move_b) begin
      a_d.valid = 1'b0;
    end

    // A word leaving during a flush is still delivered.
    if (out_fire) begin
      if (b_q.src == SRC1) cnt1_d = cnt1_q + ONE;
      else                 cnt0_d = cnt0_q + ONE;
    end

    // Drop valids only; payload stays so out_data holds.
    if (flush) begin
      a_d       = a_q;
      b_d       = b_q;
      a_d.valid = 1'b0;
      b_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      last_q <= SRC1;
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      last_q <= last_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign gnt0      = gnt[0];
  assign gnt1      = gnt[1];
  assign out_data  = b_q.data;
  assign out_src   = b_q.src;
  assign out_valid = b_q.valid;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule
